// File: rtl/button_gesture.sv
// Push-button conditioner: 2-flop sync, ms-based debounce, short/long/double press gesture decode.
// Latency: btn_level follows a clean raw edge after 2 cycles + (DEBOUNCE_MS-1..DEBOUNCE_MS) ms; all outputs registered.
// Backpressure: none; outputs are levels or one-cycle pulses that the consumer must sample every cycle.
module button_gesture #(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 800,
    parameter int unsigned DOUBLE_MS   = 300
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_press
);

    localparam int unsigned PRESCALE = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] P_LAST    = PW'(PRESCALE - 1);
    localparam logic [15:0]   DB_LAST   = 16'(DEBOUNCE_MS - 1);
    localparam logic [15:0]   LONG_LAST = 16'(LONG_MS - 1);
    localparam logic [15:0]   DBL_LAST  = 16'(DOUBLE_MS - 1);
    localparam logic [15:0]   CNT_MAX   = 16'hFFFF;
    localparam logic          RAW_IDLE  = ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic sync_q1;
    logic sync_q2;
    logic pressed_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= RAW_IDLE;
            sync_q2 <= RAW_IDLE;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed_s = sync_q2 ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // 1 ms prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] pcnt;
    logic          ms_tick;

    assign ms_tick = (pcnt == P_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (ms_tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce: accept the new level on the tick that completes DEBOUNCE_MS
    // ------------------------------------------------------------------
    logic [15:0] db_cnt;
    logic        db_diff;
    logic        db_accept;
    logic        press_evt;
    logic        release_evt;

    assign db_diff     = (pressed_s != btn_level);
    assign db_accept   = db_diff && ms_tick && (db_cnt == DB_LAST);
    assign press_evt   = db_accept && pressed_s;
    assign release_evt = db_accept && !pressed_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            if (!db_diff || db_accept) begin
                db_cnt <= '0;
            end else if (ms_tick && (db_cnt != CNT_MAX)) begin
                db_cnt <= db_cnt + 16'd1;
            end
            if (db_accept) begin
                btn_level <= pressed_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Gesture FSM; decisions use the debounce events so gesture pulses
    // line up with press_pulse/release_pulse in the same cycle.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tcnt;
    logic        long_due;
    logic        dbl_due;
    logic        short_nxt;
    logic        long_nxt;
    logic        double_nxt;

    assign long_due = ms_tick && (tcnt == LONG_LAST);
    assign dbl_due  = ms_tick && (tcnt == DBL_LAST);

    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                // a release landing on the long-press tick wins
                if (release_evt) begin
                    state_nxt = GAP;
                end else if (long_due) begin
                    long_nxt  = 1'b1;
                    state_nxt = WAIT_REL;
                end
            end
            GAP: begin
                if (press_evt) begin
                    double_nxt = 1'b1;
                    state_nxt  = WAIT_REL;
                end else if (dbl_due) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_REL: begin
                if (release_evt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tcnt         <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
        end else begin
            state        <= state_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_press <= double_nxt;
            if (state_nxt != state) begin
                tcnt <= '0;
            end else if (ms_tick && (tcnt != CNT_MAX)) begin
                tcnt <= tcnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: timed gesture stimulus feeds an expected-event queue; a forked monitor pops and checks each pulse.
// Timing windows come from the ms arithmetic of the behaviour (1 ms = P cycles), not from the RTL structure.
module tb_button_gesture;

    localparam int P   = 10;   // cycles per ms at CLK_HZ = 10_000
    localparam int DMS = 2;
    localparam int LMS = 10;
    localparam int GMS = 5;

    // raw edge -> debounced edge: 2 sync cycles, DMS-1 full ms, then up to one more ms
    localparam int DB_LO    = 2 + (DMS - 1) * P + 1;
    localparam int DB_HI    = 2 + DMS * P;
    localparam int LONG_LO  = (LMS - 1) * P + 1;
    localparam int LONG_HI  = LMS * P;
    localparam int SHORT_LO = (GMS - 1) * P + 1;
    localparam int SHORT_HI = GMS * P;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_SHORT, EV_LONG, EV_DOUBLE} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        bit       rel;   // window relative to the previously matched event
        int       lo;
        int       hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b1;
    logic btn_level, press_pulse, release_pulse, short_press, long_press, double_press;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   prev_t = 0;
    int   rel_count = 0;

    button_gesture #(
        .CLK_HZ(10_000), .ACTIVE_LOW(1'b1), .DEBOUNCE_MS(DMS), .LONG_MS(LMS), .DOUBLE_MS(GMS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_press(short_press), .long_press(long_press), .double_press(double_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input ev_kind_e k, input bit rel, input int lo, input int hi);
        exp_t e;
        e.kind = k; e.rel = rel; e.lo = lo; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic match(input ev_kind_e k);
        exp_t e;
        int lo, hi;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            lo = e.rel ? prev_t + e.lo : e.lo;
            hi = e.rel ? prev_t + e.hi : e.hi;
            if (e.kind != k || cyc < lo || cyc > hi) begin
                errors++;
                $display("FAIL event_order: got %s at cycle %0d, required %s in cycles [%0d,%0d]",
                         k.name(), cyc, e.kind.name(), lo, hi);
            end
        end
        prev_t = cyc;
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (short_press || long_press || double_press) begin
                checks++;
                if (int'(short_press) + int'(long_press) + int'(double_press) > 1) begin
                    errors++;
                    $display("FAIL gesture_onehot: got s/l/d=%b%b%b at cycle %0d, required at most one",
                             short_press, long_press, double_press, cyc);
                end
            end
            if (press_pulse)   match(EV_PRESS);
            if (release_pulse) begin
                rel_count++;
                match(EV_RELEASE);
            end
            if (long_press)    match(EV_LONG);
            if (short_press)   match(EV_SHORT);
            if (double_press)  match(EV_DOUBLE);
        end
    endtask

    task automatic chk_level(input logic exp_lvl);
        checks++;
        if (btn_level !== exp_lvl) begin
            errors++;
            $display("FAIL btn_level: got %b at cycle %0d, required %b", btn_level, cyc, exp_lvl);
        end
    endtask

    task automatic chk_drained();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_event: %0d pending at cycle %0d (next %s), required 0",
                     exp_q.size(), cyc, exp_q[0].kind.name());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            checks++;
            if ({btn_level, press_pulse, release_pulse, short_press, long_press, double_press} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b at cycle %0d, required 000000",
                         {btn_level, press_pulse, release_pulse, short_press, long_press, double_press}, cyc);
            end
        end
        rst_n = 1'b1;
    endtask

    // mode 0: clean edge; 1: random bounce; 2: toggle every 5 cycles for 40 cycles
    task automatic set_btn(input bit pressed, input int mode);
        int n;
        int w;
        n = (mode == 2) ? 8 : 2 * $urandom_range(1, 3);
        if (mode != 0) begin
            for (int i = 0; i < n; i++) begin
                btn_raw = (i % 2 == 0) ? !pressed : pressed;
                w = (mode == 2) ? 5 : $urandom_range(1, 5);
                tick(w);
            end
        end
        btn_raw = !pressed;
        push(pressed ? EV_PRESS : EV_RELEASE, 1'b0, cyc + DB_LO, cyc + DB_HI);
    endtask

    task automatic do_short(input int hold, input int m1, input int m2);
        set_btn(1'b1, m1);
        tick(hold);
        chk_level(1'b1);
        set_btn(1'b0, m2);
        push(EV_SHORT, 1'b1, SHORT_LO, SHORT_HI);
        tick($urandom_range(80, 120));
        chk_level(1'b0);
        chk_drained();
    endtask

    task automatic do_long(input int hold, input int m1, input int m2);
        set_btn(1'b1, m1);
        push(EV_LONG, 1'b1, LONG_LO, LONG_HI);
        tick(hold);
        chk_level(1'b1);
        set_btn(1'b0, m2);
        tick($urandom_range(100, 140));
        chk_level(1'b0);
        chk_drained();
    endtask

    task automatic do_double(input int h1, input int gap, input int h2);
        set_btn(1'b1, 0);
        tick(h1);
        set_btn(1'b0, 0);
        tick(gap);
        set_btn(1'b1, 0);
        push(EV_DOUBLE, 1'b1, 0, 0);
        tick(h2);
        chk_level(1'b1);
        set_btn(1'b0, 0);
        tick($urandom_range(60, 100));
        chk_level(1'b0);
        chk_drained();
    endtask

    initial begin
        int start;
        int kind;
        fork
            monitor_loop();
        join_none

        // reset with the button released, then a long quiet stretch
        btn_raw = 1'b1;
        tick(1);
        do_reset(50);
        tick(200);
        chk_level(1'b0);
        chk_drained();

        do_short(40, 2, 0);                       // bounced press
        do_short(40, 0, 0);                       // clean short press
        do_long(200, 0, 0);                       // long press, no short afterwards
        do_double(40, 30, 40);                    // double press

        // reset during the release gap aborts the pending short press
        set_btn(1'b1, 0);
        tick(40);
        set_btn(1'b0, 0);
        start = rel_count;
        for (int i = 0; i < 40 && rel_count == start; i++) tick(1);
        checks++;
        if (rel_count == start) begin
            errors++;
            $display("FAIL gap_release_timeout: got no release_pulse by cycle %0d, required one", cyc);
        end
        tick(10);
        do_reset(5);
        tick(120);
        chk_level(1'b0);
        chk_drained();
        do_long(150, 0, 0);                       // FSM back in IDLE: a fresh press decodes normally

        for (int g = 0; g < 16; g++) begin
            kind = $urandom_range(0, 2);
            case (kind)
                0:       do_short($urandom_range(25, 50), $urandom_range(0, 1), $urandom_range(0, 1));
                1:       do_long($urandom_range(120, 200), $urandom_range(0, 1), $urandom_range(0, 1));
                default: do_double($urandom_range(25, 50), $urandom_range(24, 30), $urandom_range(25, 150));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
